store_scoreboard: RTL and testbench



---
 rtl/store_scoreboard.sv | 150 +++++++++++++++
 tb/tb_store_scoreboard.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/store_scoreboard.sv
// Store monitor: checks data-memory writes against an ordered table of expected
// (address, data) pairs, with a cycle-bounded timeout and a sticky verdict.
module store_scoreboard #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 100,
   parameter int STRICT  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
   input  logic [WIDTH-1:0]           cfg_adr,
   input  logic [WIDTH-1:0]           cfg_data,
   input  logic [$clog2(DEPTH):0]     cfg_count,
   input  logic                       start,
   input  logic                       MemWrite,
   input  logic [WIDTH-1:0]           DataAdr,
   input  logic [WIDTH-1:0]           WriteData,
   output logic                       done,
   output logic                       pass,
   output logic [1:0]                 fail_code,
   output logic [$clog2(DEPTH):0]     match_cnt,
   output logic [31:0]                cycle_cnt,
   output logic [WIDTH-1:0]           err_adr,
   output logic [WIDTH-1:0]           err_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   localparam logic [1:0] FC_NONE = 2'd0;
   localparam logic [1:0] FC_DATA = 2'd1;
   localparam logic [1:0] FC_ADR  = 2'd2;
   localparam logic [1:0] FC_TOUT = 2'd3;

   state_t           state, state_nx;
   logic [CW-1:0]    count_q, count_nx;
   logic [CW-1:0]    match_nx, match_inc;
   logic [31:0]      cycle_nx;
   logic [WIDTH-1:0] err_adr_nx, err_data_nx;
   logic [1:0]       fail_code_nx;
   logic             done_nx, pass_nx;
   logic             adr_hit, data_hit, timeout;

   logic [WIDTH-1:0] tbl_adr  [DEPTH];
   logic [WIDTH-1:0] tbl_data [DEPTH];

   // Table is frozen during RUN so the expected sequence cannot shift mid-check.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_adr[i]  <= '0;
            tbl_data[i] <= '0;
         end
      end else if (cfg_we && state != RUN) begin
         tbl_adr[cfg_idx]  <= cfg_adr;
         tbl_data[cfg_idx] <= cfg_data;
      end
   end

   assign adr_hit   = (DataAdr   == tbl_adr[match_cnt[IW-1:0]]);
   assign data_hit  = (WriteData == tbl_data[match_cnt[IW-1:0]]);
   assign timeout   = (cycle_cnt == 32'(TIMEOUT - 1));
   assign match_inc = match_cnt + 1'b1;

   always_comb begin
      state_nx     = state;
      count_nx     = count_q;
      match_nx     = match_cnt;
      cycle_nx     = cycle_cnt;
      err_adr_nx   = err_adr;
      err_data_nx  = err_data;
      fail_code_nx = fail_code;
      done_nx      = done;
      pass_nx      = pass;
      case (state)
         IDLE, PASS, FAIL: begin
            if (start) begin
               count_nx     = cfg_count;
               match_nx     = '0;
               cycle_nx     = '0;
               err_adr_nx   = '0;
               err_data_nx  = '0;
               fail_code_nx = FC_NONE;
               if (cfg_count == '0) begin
                  state_nx = PASS;
                  done_nx  = 1'b1;
                  pass_nx  = 1'b1;
               end else begin
                  state_nx = RUN;
                  done_nx  = 1'b0;
                  pass_nx  = 1'b0;
               end
            end
         end
         RUN: begin
            if (cycle_cnt != '1) cycle_nx = cycle_cnt + 32'd1;
            if (MemWrite && adr_hit && data_hit) begin
               match_nx = match_inc;
               if (match_inc == count_q) begin
                  state_nx = PASS;
                  done_nx  = 1'b1;
                  pass_nx  = 1'b1;
               end
            end else if (MemWrite && STRICT != 0) begin
               state_nx     = FAIL;
               done_nx      = 1'b1;
               fail_code_nx = adr_hit ? FC_DATA : FC_ADR;
               err_adr_nx   = DataAdr;
               err_data_nx  = WriteData;
            end
            // A store verdict in the same cycle takes precedence over timeout.
            if (state_nx == RUN && timeout) begin
               state_nx     = FAIL;
               done_nx      = 1'b1;
               fail_code_nx = FC_TOUT;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count_q   <= '0;
         match_cnt <= '0;
         cycle_cnt <= '0;
         err_adr   <= '0;
         err_data  <= '0;
         fail_code <= FC_NONE;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         state     <= state_nx;
         count_q   <= count_nx;
         match_cnt <= match_nx;
         cycle_cnt <= cycle_nx;
         err_adr   <= err_adr_nx;
         err_data  <= err_data_nx;
         fail_code <= fail_code_nx;
         done      <= done_nx;
         pass      <= pass_nx;
      end
   end

endmodule

// File: tb/tb_store_scoreboard.sv
// Directed bench: a strict and a lenient scoreboard share one stimulus stream,
// each checked against hand-computed verdicts.
module tb_store_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [31:0] cfg_adr, cfg_data;
   logic [3:0]  cfg_count;
   logic        start;
   logic        MemWrite;
   logic [31:0] DataAdr, WriteData;

   logic        s_done, s_pass, l_done, l_pass;
   logic [1:0]  s_fc, l_fc;
   logic [3:0]  s_mc, l_mc;
   logic [31:0] s_cc, l_cc, s_ea, l_ea, s_ed, l_ed;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_scoreboard #(.WIDTH(32), .DEPTH(8), .TIMEOUT(10), .STRICT(1)) u_strict (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
      .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .done(s_done), .pass(s_pass),
      .fail_code(s_fc), .match_cnt(s_mc), .cycle_cnt(s_cc), .err_adr(s_ea), .err_data(s_ed));

   store_scoreboard #(.WIDTH(32), .DEPTH(8), .TIMEOUT(10), .STRICT(0)) u_lax (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
      .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .MemWrite(MemWrite),
      .DataAdr(DataAdr), .WriteData(WriteData), .done(l_done), .pass(l_pass),
      .fail_code(l_fc), .match_cnt(l_mc), .cycle_cnt(l_cc), .err_adr(l_ea), .err_data(l_ed));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_adr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic go(input int cnt);
      cfg_count = 4'(cnt); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      tick();
      MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
      cfg_count = '0; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
      tick(2);
      chk("rst_done", {s_done, l_done}, 2'b00);
      chk("rst_pass", {s_pass, l_pass}, 2'b00);
      chk("rst_cnts", {s_fc, s_mc, s_cc}, '0);
      chk("rst_err", {s_ea, s_ed}, '0);
      reset = 1'b0;

      // single store in cycle 5
      prog(0, 100, 25);
      go(1);
      tick(4);
      chk("t1_pending", {s_done, s_cc}, {1'b0, 32'd4});
      store(100, 25);
      chk("t1_verdict", {s_done, s_pass, s_fc}, {1'b1, 1'b1, 2'd0});
      chk("t1_mc", s_mc, 4'd1);
      chk("t1_cc", s_cc, 32'd5);
      chk("t1_lax", {l_done, l_pass, l_mc}, {1'b1, 1'b1, 4'd1});

      // data mismatch
      go(1);
      store(100, 7);
      chk("t2_verdict", {s_done, s_pass, s_fc}, {1'b1, 1'b0, 2'd1});
      chk("t2_err", {s_ea, s_ed}, {32'd100, 32'd7});
      chk("t2_lax_run", l_done, 1'b0);
      tick(10);
      chk("t2_lax_tout", {l_done, l_pass, l_fc, l_cc}, {1'b1, 1'b0, 2'd3, 32'd10});
      chk("t2_frozen", {s_cc, s_ea}, {32'd1, 32'd100});

      // unexpected address, then the lenient one completes
      prog(0, 96, 7);
      prog(1, 100, 25);
      go(2);
      store(104, 9);
      chk("t3_verdict", {s_done, s_pass, s_fc}, {1'b1, 1'b0, 2'd2});
      chk("t3_err", {s_ea, s_ed}, {32'd104, 32'd9});
      store(96, 7);
      chk("t3_lax_mid", {l_done, l_mc}, {1'b0, 4'd1});
      store(100, 25);
      chk("t3_lax", {l_done, l_pass, l_mc, l_cc}, {1'b1, 1'b1, 4'd2, 32'd3});
      chk("t3_strict_frz", {s_ea, s_mc, s_cc}, {32'd104, 4'd0, 32'd1});

      // timeout with no stores
      go(1);
      tick(9);
      chk("t4_pre", {s_done, l_done, s_cc}, {1'b0, 1'b0, 32'd9});
      tick();
      chk("t4_tout", {s_done, s_pass, s_fc, s_cc}, {1'b1, 1'b0, 2'd3, 32'd10});
      chk("t4_err", {s_ea, s_ed}, '0);

      // final match in the timeout cycle beats timeout
      go(1);
      tick(9);
      store(96, 7);
      chk("t4_race", {s_done, s_pass, s_fc, s_cc}, {1'b1, 1'b1, 2'd0, 32'd10});
      chk("t4_race_lax", {l_pass, l_fc}, {1'b1, 2'd0});

      // full table
      for (int i = 0; i < 8; i++) prog(i, 32'(64 + 4 * i), 32'(1000 + i));
      go(8);
      for (int i = 0; i < 8; i++) store(32'(64 + 4 * i), 32'(1000 + i));
      chk("t5_full", {s_done, s_pass, s_mc, s_cc}, {1'b1, 1'b1, 4'd8, 32'd8});
      go(0);
      chk("t5_zero", {s_done, s_pass, s_mc, s_cc}, {1'b1, 1'b1, 4'd0, 32'd0});

      // reset mid-run clears table and outputs
      prog(0, 100, 25);
      prog(1, 104, 26);
      prog(2, 108, 27);
      go(3);
      store(100, 25);
      store(104, 26);
      chk("t6_mid", {s_done, s_mc}, {1'b0, 4'd2});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst", {s_done, s_pass, s_fc, s_mc, s_cc, s_ea, s_ed}, '0);
      chk("t6_rst_lax", {l_done, l_pass, l_mc, l_cc}, '0);
      prog(1, 104, 26);
      go(2);
      store(100, 25);
      chk("t6_stale", {s_done, s_fc, s_ea, s_ed}, {1'b1, 2'd2, 32'd100, 32'd25});
      chk("t6_stale_lax", {l_done, l_mc}, {1'b0, 4'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule
